alu_vectorial: RTL and testbench

//  SIMD ALU: n_alu independent unsigned WIDTH-bit lanes share one opcode and one enable.

---
 rtl/alu_vectorial.sv | 81 ++++++++
 tb/tb_alu_vectorial.sv | 112 +++++++++++
 2 files changed

// File: rtl/alu_vectorial.sv
// alu_vectorial: n_alu-lane SIMD ALU with registered results and compare flags.
// Define ALU_DIV_EN to include the per-lane divider on opcode 110.
module alu_vectorial #(
   parameter int WIDTH = 8,
   parameter int n_alu = 4
) (
   input  logic                       clk,
   input  logic                       arst,
   input  logic [WIDTH*n_alu-1:0]     a,
   input  logic [WIDTH*n_alu-1:0]     b,
   input  logic [2:0]                 select,
   input  logic                       enable,
   output logic [n_alu-1:0]           carry_out,
   output logic [n_alu-1:0]           a_greater,
   output logic [n_alu-1:0]           a_equal,
   output logic [n_alu-1:0]           a_less,
   output logic [n_alu-1:0]           inf,
   output logic [2*WIDTH*n_alu-1:0]   data_out
);
   logic [n_alu-1:0]         c_nxt, g_nxt, e_nxt, l_nxt, i_nxt;
   logic [2*WIDTH*n_alu-1:0] d_nxt;

   genvar i;
   for (i = 0; i < n_alu; i++) begin : g_lane
      logic [WIDTH-1:0]   x, y, q, m;
      logic [WIDTH:0]     s, d;
      logic [2*WIDTH-1:0] r;
      logic               c, z;
      assign x = a[WIDTH*i +: WIDTH];
      assign y = b[WIDTH*i +: WIDTH];
      assign s = {1'b0, x} + {1'b0, y};
      assign d = {1'b0, x} - {1'b0, y};
`ifdef ALU_DIV_EN
      assign z = (select == 3'b110) && (y == '0);
      assign q = (y == '0) ? '1 : x / y;
      assign m = (y == '0) ? x : x % y;
`else
      assign z = 1'b0;
      assign q = '0;
      assign m = '0;
`endif
      always_comb begin
         r = '0;
         c = 1'b0;
         case (select)
            3'b000: begin r = {{WIDTH{1'b0}}, s[WIDTH-1:0]}; c = s[WIDTH]; end
            3'b001: begin r = {{WIDTH{1'b0}}, d[WIDTH-1:0]}; c = d[WIDTH]; end
            3'b010: r = {{WIDTH{1'b0}}, x & y};
            3'b011: r = {{WIDTH{1'b0}}, x | y};
            3'b100: r = {{WIDTH{1'b0}}, x ^ y};
            3'b101: r = {{WIDTH{1'b0}}, x} << y[2:0];
            3'b110: r = {m, q};
            default: r = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
         endcase
      end
      assign d_nxt[2*WIDTH*i +: 2*WIDTH] = r;
      assign c_nxt[i] = c;
      assign i_nxt[i] = z;
      assign g_nxt[i] = x > y;
      assign e_nxt[i] = x == y;
      assign l_nxt[i] = x < y;
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         data_out  <= '0;
         carry_out <= '0;
         a_greater <= '0;
         a_equal   <= '0;
         a_less    <= '0;
         inf       <= '0;
      end else if (enable) begin
         data_out  <= d_nxt;
         carry_out <= c_nxt;
         a_greater <= g_nxt;
         a_equal   <= e_nxt;
         a_less    <= l_nxt;
         inf       <= i_nxt;
      end
   end
endmodule

// File: tb/tb_alu_vectorial.sv
// tb_alu_vectorial: directed and swept checks of alu_vectorial (WIDTH=8, n_alu=4).
module tb_alu_vectorial;
   logic        clk = 1'b0, arst = 1'b1, enable = 1'b0;
   logic [2:0]  select = '0;
   logic [31:0] a = '0, b = '0;
   logic [3:0]  carry_out, a_greater, a_equal, a_less, inf;
   logic [63:0] data_out;
   int passed = 0, total = 0;

   always #5 clk = ~clk;

   alu_vectorial #(.WIDTH(8), .n_alu(4)) dut (
      .clk(clk), .arst(arst), .a(a), .b(b), .select(select), .enable(enable),
      .carry_out(carry_out), .a_greater(a_greater), .a_equal(a_equal),
      .a_less(a_less), .inf(inf), .data_out(data_out)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   task automatic expect_all(input string tag, input logic [63:0] d, input logic [3:0] c,
                             input logic [3:0] g, input logic [3:0] e, input logic [3:0] l,
                             input logic [3:0] f);
      check({tag, " data"}, data_out, d);
      check({tag, " carry"}, {60'b0, carry_out}, {60'b0, c});
      check({tag, " gt"}, {60'b0, a_greater}, {60'b0, g});
      check({tag, " eq"}, {60'b0, a_equal}, {60'b0, e});
      check({tag, " lt"}, {60'b0, a_less}, {60'b0, l});
      check({tag, " inf"}, {60'b0, inf}, {60'b0, f});
   endtask

   task automatic step(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y);
      select = s;
      a = x;
      b = y;
      enable = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] x, y;
      logic [63:0] ed;
      logic [3:0]  ec, eg, ee, el;
      logic [8:0]  sum;
      #2 arst = 1'b0;
      #1 expect_all("reset", 64'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      step(3'b000, 32'h01010101, 32'h01010101);
      step(3'b000, 32'h01010101, 32'h01010101);
      expect_all("reset hold", 64'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      arst = 1'b1;
      step(3'b000, 32'h01010101, 32'h01010101);
      expect_all("add ones", 64'h0002000200020002, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);
      #2 arst = 1'b0;
      #1 expect_all("async reset", 64'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      arst = 1'b1;
      step(3'b000, 32'h0, 32'h0);
      expect_all("add zero", 64'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);

      step(3'b000, 32'hFF108000, 32'h01208000);
      expect_all("add", 64'h0000003000000000, 4'b1010, 4'b1000, 4'b0011, 4'b0100, 4'h0);
      step(3'b001, 32'h0500FF7F, 32'h0301FF80);
      expect_all("sub", 64'h000200FF000000FF, 4'b0101, 4'b1000, 4'b0010, 4'b0101, 4'h0);
      step(3'b010, 32'hF0AA3C0F, 32'hFF55F00F);
      expect_all("and", 64'h00F000000030000F, 4'h0, 4'b0100, 4'b0001, 4'b1010, 4'h0);
      step(3'b011, 32'hF0AA3C0F, 32'hFF55F00F);
      check("or data", data_out, 64'h00FF00FF00FC000F);
      step(3'b100, 32'hF0AA3C0F, 32'hFF55F00F);
      check("xor data", data_out, 64'h000F00FF00CC0000);
      step(3'b101, 32'h01FF8003, 32'h07010F00);
      expect_all("shl", 64'h008001FE40000003, 4'h0, 4'b0111, 4'b0000, 4'b1000, 4'h0);
      step(3'b110, 32'h0709FF00, 32'h02001005);
`ifdef ALU_DIV_EN
      expect_all("div", 64'h010309FF0F0F0000, 4'h0, 4'b1110, 4'b0000, 4'b0001, 4'b0100);
`else
      expect_all("div off", 64'h0, 4'h0, 4'b1110, 4'b0000, 4'b0001, 4'h0);
`endif
      step(3'b111, 32'hFF020010, 32'hFF035510);
      expect_all("mul", 64'hFE01000600000100, 4'h0, 4'b0000, 4'b1001, 4'b0110, 4'h0);

      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         select = 3'(k);
         a = $urandom;
         b = $urandom;
         @(posedge clk);
         #1 expect_all("hold", 64'hFE01000600000100, 4'h0, 4'b0000, 4'b1001, 4'b0110, 4'h0);
      end

      for (int k = 0; k < 20; k++) begin
         x = $urandom;
         y = $urandom;
         if (k % 3 == 0) y[8*(k%4) +: 8] = x[8*(k%4) +: 8];
         for (int j = 0; j < 4; j++) begin
            sum = {1'b0, x[8*j +: 8]} + {1'b0, y[8*j +: 8]};
            ed[16*j +: 16] = {8'h00, sum[7:0]};
            ec[j] = sum[8];
            eg[j] = x[8*j +: 8] > y[8*j +: 8];
            ee[j] = x[8*j +: 8] == y[8*j +: 8];
            el[j] = x[8*j +: 8] < y[8*j +: 8];
         end
         step(3'b000, x, y);
         expect_all("sweep", ed, ec, eg, ee, el, 4'h0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
